// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
//   arb_state_e : transaction FSM states (idle / downstream busy / result hand-back)
//   mem_txn_t   : captured downstream transaction at the default 32-bit widths
//   rr_wrap     : modular channel index helper used by the round-robin scan
package mem_arb_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_MASK_W = ARB_DATA_W / 8;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_DONE} arb_state_e;

  typedef struct packed {
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wd;
    logic [ARB_MASK_W-1:0] mask;
  } mem_txn_t;

  function automatic int rr_wrap(int base, int off, int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req    : request vector, one bit per channel
//   rr_ptr : highest-priority channel for this scan
//   valid  : at least one channel requests
//   idx    : first requester found scanning rr_ptr, rr_ptr+1, ... mod NUM_CH
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter  int NUM_CH = 2,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   rr_ptr,
  output logic              valid,
  output logic [CH_W-1:0]   idx
);

  // Scan farthest offset first so the nearest requester to rr_ptr is the
  // last one written and therefore wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req[rr_wrap(int'(rr_ptr), k, NUM_CH)]) begin
        valid = 1'b1;
        idx   = CH_W'(rr_wrap(int'(rr_ptr), k, NUM_CH));
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel round-robin arbiter merging requesters onto one memory port.
//   clk, reset          : clock, synchronous active-high reset
//   ch_req/we/addr/wd/mask : per-channel request, packed channel-major
//   ch_rd, ch_wait      : per-channel read data and stall
//   mem_req/we/addr/wd/mask : registered downstream request, held until mem_ack
//   mem_ack, mem_rd     : downstream completion and read data
//   grant_id            : channel owning the current transaction
// A transaction takes IDLE (capture) -> BUSY (until ack) -> DONE (one-cycle
// hand-back), so a requester unstalls 2+k cycles after being seen.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NUM_CH = 2,
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int MASK_W = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_we,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wd,
  input  logic [NUM_CH*MASK_W-1:0] ch_mask,
  output logic [NUM_CH*DATA_W-1:0] ch_rd,
  output logic [NUM_CH-1:0]        ch_wait,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wd,
  output logic [MASK_W-1:0]        mem_mask,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_rd,
  output logic [CH_W-1:0]          grant_id
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
    logic [MASK_W-1:0] mask;
  } txn_t;

  logic [NUM_CH-1:0][ADDR_W-1:0] addr_a;
  logic [NUM_CH-1:0][DATA_W-1:0] wd_a;
  logic [NUM_CH-1:0][MASK_W-1:0] mask_a;

  assign addr_a = ch_addr;
  assign wd_a   = ch_wd;
  assign mask_a = ch_mask;

  arb_state_e        state, state_d;
  logic [CH_W-1:0]   rr_ptr, rr_ptr_d;
  logic [CH_W-1:0]   grant_d;
  logic [CH_W-1:0]   pick_idx;
  logic              pick_vld;
  txn_t              txn, txn_d;
  logic              req_d;
  logic [DATA_W-1:0] rd_buf, rd_buf_d;

  rr_picker #(.NUM_CH(NUM_CH)) u_pick (
    .req    (ch_req),
    .rr_ptr (rr_ptr),
    .valid  (pick_vld),
    .idx    (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      mem_req  <= 1'b0;
      txn      <= '0;
      rd_buf   <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_d;
      rr_ptr   <= rr_ptr_d;
      mem_req  <= req_d;
      txn      <= txn_d;
      rd_buf   <= rd_buf_d;
      grant_id <= grant_d;
    end
  end

  always_comb begin
    state_d  = state;
    rr_ptr_d = rr_ptr;
    req_d    = mem_req;
    txn_d    = txn;
    rd_buf_d = rd_buf;
    grant_d  = grant_id;
    unique case (state)
      ARB_IDLE: begin
        if (pick_vld) begin
          txn_d.we   = ch_we[pick_idx];
          txn_d.addr = addr_a[pick_idx];
          txn_d.wd   = wd_a[pick_idx];
          txn_d.mask = mask_a[pick_idx];
          grant_d    = pick_idx;
          req_d      = 1'b1;
          state_d    = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // The transaction runs to completion even if the owner drops its
        // request; writes already issued downstream cannot be recalled.
        if (mem_ack) begin
          rd_buf_d = mem_rd;
          req_d    = 1'b0;
          state_d  = ARB_DONE;
        end
      end
      ARB_DONE: begin
        // With one channel the wrap keeps rr_ptr pinned at 0.
        rr_ptr_d = (grant_id == CH_W'(NUM_CH - 1)) ? '0 : grant_id + 1'b1;
        state_d  = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign mem_we   = txn.we;
  assign mem_addr = txn.addr;
  assign mem_wd   = txn.wd;
  assign mem_mask = txn.mask;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    assign ch_wait[i] = ch_req[i] & ~((state == ARB_DONE) && (grant_id == CH_W'(i)));
    assign ch_rd[i*DATA_W +: DATA_W] = rd_buf;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (4 channels): directed scenarios
// followed by randomized traffic checked against a behavioural model.
module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    ch_req, ch_we;
  logic [N*AW-1:0] ch_addr;
  logic [N*DW-1:0] ch_wd;
  logic [N*MW-1:0] ch_mask;
  logic [N*DW-1:0] ch_rd;
  logic [N-1:0]    ch_wait;
  logic            mem_req, mem_we, mem_ack;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wd, mem_rd;
  logic [MW-1:0]   mem_mask;
  logic [CW-1:0]   grant_id;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_wd(ch_wd), .ch_mask(ch_mask),
    .ch_rd(ch_rd), .ch_wait(ch_wait),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_mask(mem_mask),
    .mem_ack(mem_ack), .mem_rd(mem_rd), .grant_id(grant_id)
  );

  // Downstream responder: acks ack_k cycles after mem_req rises (random k in
  // random mode); optional spurious acks whenever no request is outstanding.
  int          ack_k = 0;
  int          age = 0;
  int          cur_k = 0;
  bit          rsp_rand = 1'b0;
  bit          spur = 1'b0;
  logic [DW-1:0] rd_val = '0;

  initial begin
    mem_ack = 1'b0;
    mem_rd  = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_req) begin
        if (age == 0) cur_k = rsp_rand ? int'($urandom_range(0, 3)) : ack_k;
        mem_ack = (age == cur_k);
        age++;
      end else begin
        age = 0;
        mem_ack = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      mem_rd = rsp_rand ? DW'($urandom) : rd_val;
    end
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_ch(input int i, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [MW-1:0] m);
    ch_we[i] = we;
    ch_addr[i*AW +: AW] = a;
    ch_wd[i*DW +: DW] = wd;
    ch_mask[i*MW +: MW] = m;
  endtask

  task automatic test_reset();
    reset = 1'b1; ch_req = '0; ch_we = '0; ch_addr = '0; ch_wd = '0; ch_mask = '0;
    cyc(); cyc(); #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_cmp++; if (grant_id !== '0) begin n_bad++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    n_cmp++; if ({mem_we, mem_addr, mem_wd, mem_mask} !== '0) begin n_bad++; $display("FAIL reset_mem_txn: got %b %h %h %h want zeros", mem_we, mem_addr, mem_wd, mem_mask); end
    n_cmp++; if (ch_rd !== '0) begin n_bad++; $display("FAIL reset_ch_rd: got %h want 0", ch_rd); end
    n_cmp++; if (ch_wait !== '0) begin n_bad++; $display("FAIL reset_ch_wait: got %b want 0", ch_wait); end
    cyc(); reset = 1'b0;
  endtask

  // ch1 read, ack 2 cycles after mem_req: stalled 4 cycles, then data.
  task automatic test_single_read();
    int  n_wait = 0;
    bit  seen = 1'b0;
    ack_k = 2; rd_val = 32'hDEADBEEF;
    cyc(); set_ch(1, 1'b0, 32'h100, 32'h0, 4'hF); ch_req = 4'b0010;
    for (int t = 0; t < 10; t++) begin
      #1;
      if (t == 1) begin
        n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL read_mem_req: got %b want 1", mem_req); end
        n_cmp++; if (mem_addr !== 32'h100) begin n_bad++; $display("FAIL read_mem_addr: got %h want 100", mem_addr); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL read_mem_we: got %b want 0", mem_we); end
        n_cmp++; if (grant_id !== 2'd1) begin n_bad++; $display("FAIL read_grant_id: got %0d want 1", grant_id); end
      end
      if (ch_wait[1]) n_wait++;
      else begin
        seen = 1'b1;
        n_cmp++; if (ch_rd[DW +: DW] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL read_ch_rd: got %h want deadbeef", ch_rd[DW +: DW]); end
        break;
      end
      cyc();
    end
    n_cmp++; if (!seen || n_wait != 4) begin n_bad++; $display("FAIL read_wait_cycles: got %0d (released %b) want 4", n_wait, seen); end
    cyc(); ch_req = '0;
  endtask

  // ch0 write, ack 3 cycles after mem_req; inputs scribbled while waiting.
  task automatic test_write();
    int ack_t = -1;
    int rel_t = -1;
    ack_k = 3;
    cyc(); set_ch(0, 1'b1, 32'h40, 32'h12345678, 4'b0011); ch_req = 4'b0001;
    for (int t = 0; t < 12; t++) begin
      #1;
      if (mem_req) begin
        n_cmp++;
        if ({mem_we, mem_addr, mem_wd, mem_mask} !== {1'b1, 32'h40, 32'h12345678, 4'b0011}) begin
          n_bad++; $display("FAIL write_txn_t%0d: got %b %h %h %b want 1 40 12345678 0011", t, mem_we, mem_addr, mem_wd, mem_mask);
        end
        if (mem_ack) ack_t = t;
      end
      if (!ch_wait[0]) begin rel_t = t; break; end
      if (t == 1) set_ch(0, 1'b1, 32'h80, 32'hFFFFFFFF, 4'b1100);
      cyc();
    end
    n_cmp++; if (ack_t != 4) begin n_bad++; $display("FAIL write_ack_cycle: got %0d want 4", ack_t); end
    n_cmp++; if (rel_t != 5) begin n_bad++; $display("FAIL write_release_cycle: got %0d want 5", rel_t); end
    cyc(); ch_req = '0;
  endtask

  // ch0 and ch1 request continuously with k=0: strict alternation, 6-cycle period.
  task automatic test_alternate();
    int last_rel[2] = '{-1, -1};
    int prev = -1;
    int n_rel = 0;
    int first_t = -1;
    int first_ch = -1;
    ack_k = 0;
    cyc(); set_ch(0, 1'b0, 32'hA0, 0, 4'hF); set_ch(1, 1'b0, 32'hB0, 0, 4'hF); ch_req = 4'b0011;
    for (int t = 0; t < 24; t++) begin
      #1;
      for (int i = 0; i < 2; i++) begin
        if (!ch_wait[i]) begin
          n_rel++;
          if (first_t < 0) begin first_t = t; first_ch = i; end
          n_cmp++; if (prev == i) begin n_bad++; $display("FAIL alt_order_t%0d: got ch%0d twice want alternation", t, i); end
          if (last_rel[i] >= 0) begin
            n_cmp++; if (t - last_rel[i] != 6) begin n_bad++; $display("FAIL alt_period_ch%0d: got %0d want 6", i, t - last_rel[i]); end
          end
          last_rel[i] = t; prev = i;
        end
      end
      cyc();
    end
    n_cmp++; if (first_t != 2 || first_ch != 1) begin n_bad++; $display("FAIL alt_first: got t%0d ch%0d want t2 ch1", first_t, first_ch); end
    n_cmp++; if (n_rel != 8) begin n_bad++; $display("FAIL alt_count: got %0d want 8", n_rel); end
    ch_req = '0;
    repeat (4) cyc();
  endtask

  // ch1 drops in BUSY; transaction completes, DONE visited, ch0 granted next.
  task automatic test_abandon();
    ack_k = 3;
    cyc(); set_ch(1, 1'b1, 32'h200, 32'h55, 4'hF); set_ch(0, 1'b0, 32'h300, 0, 4'hF); ch_req = 4'b0010;
    for (int t = 0; t < 12; t++) begin
      if (t == 1) ch_req = 4'b0001;
      #1;
      n_cmp++; if (ch_wait[1] !== 1'b0 && t > 0) begin n_bad++; $display("FAIL abandon_wait1_t%0d: got 1 want 0", t); end
      if (t >= 1 && t <= 4) begin
        n_cmp++; if (mem_req !== 1'b1 || grant_id !== 2'd1) begin n_bad++; $display("FAIL abandon_busy_t%0d: got req %b gid %0d want 1 1", t, mem_req, grant_id); end
      end
      if (t == 5 || t == 6) begin
        n_cmp++; if (mem_req !== 1'b0 || ch_wait[0] !== 1'b1) begin n_bad++; $display("FAIL abandon_gap_t%0d: got req %b wait0 %b want 0 1", t, mem_req, ch_wait[0]); end
      end
      if (t == 7) begin
        n_cmp++; if (mem_req !== 1'b1 || grant_id !== 2'd0 || mem_addr !== 32'h300) begin n_bad++; $display("FAIL abandon_next: got req %b gid %0d addr %h want 1 0 300", mem_req, grant_id, mem_addr); end
      end
      if (t == 11) begin
        n_cmp++; if (ch_wait[0] !== 1'b0) begin n_bad++; $display("FAIL abandon_ch0_release: got 1 want 0"); end
      end
      cyc();
    end
    ch_req = '0;
  endtask

  // Reset during BUSY: mem_req drops, rr pointer returns to 0.
  task automatic test_reset_busy();
    ack_k = 6;
    cyc(); set_ch(2, 1'b0, 32'h400, 0, 4'hF); ch_req = 4'b0100;
    cyc(); #1;
    n_cmp++; if (mem_req !== 1'b1 || grant_id !== 2'd2) begin n_bad++; $display("FAIL rstbusy_pre: got req %b gid %0d want 1 2", mem_req, grant_id); end
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0; ack_k = 0;
    set_ch(0, 1'b0, 32'h500, 0, 4'hF); set_ch(3, 1'b0, 32'h600, 0, 4'hF); ch_req = 4'b1001; #1;
    n_cmp++; if (mem_req !== 1'b0 || grant_id !== 2'd0) begin n_bad++; $display("FAIL rstbusy_post: got req %b gid %0d want 0 0", mem_req, grant_id); end
    cyc(); #1;
    n_cmp++; if (mem_req !== 1'b1 || grant_id !== 2'd0) begin n_bad++; $display("FAIL rstbusy_first_grant: got req %b gid %0d want 1 0", mem_req, grant_id); end
    cyc(); #1;
    n_cmp++; if (ch_wait !== 4'b1000) begin n_bad++; $display("FAIL rstbusy_release: got %b want 1000", ch_wait); end
    cyc(); ch_req = 4'b1000;
    cyc(); cyc(); #1;
    n_cmp++; if (ch_wait !== 4'b0000) begin n_bad++; $display("FAIL rstbusy_ch3: got %b want 0000", ch_wait); end
    cyc(); ch_req = '0;
  endtask

  // All four request with spurious acks outside BUSY: order 0,1,2,3,0, 4-cycle period.
  task automatic test_all_four();
    int order[5] = '{0, 1, 2, 3, 0};
    int n_rel = 0;
    int last_t = -1;
    ack_k = 1; spur = 1'b1;
    for (int i = 0; i < N; i++) set_ch(i, 1'b0, AW'(32'h1000 + i), 0, 4'hF);
    cyc(); ch_req = 4'b1111;
    for (int t = 0; t < 30 && n_rel < 5; t++) begin
      #1;
      for (int i = 0; i < N; i++) begin
        if (!ch_wait[i]) begin
          n_cmp++; if (i != order[n_rel]) begin n_bad++; $display("FAIL four_order_%0d: got ch%0d want ch%0d", n_rel, i, order[n_rel]); end
          if (last_t >= 0) begin
            n_cmp++; if (t - last_t != 4) begin n_bad++; $display("FAIL four_period_%0d: got %0d want 4", n_rel, t - last_t); end
          end
          last_t = t; n_rel++;
        end
      end
      cyc();
    end
    n_cmp++; if (n_rel != 5) begin n_bad++; $display("FAIL four_count: got %0d want 5", n_rel); end
    spur = 1'b0; ch_req = '0;
    repeat (4) cyc();
  endtask

  // Randomized traffic against a transaction-window model.
  task automatic test_random();
    bit            m_busy = 1'b0, m_rel = 1'b0;
    int            m_owner = 0, m_ptr = 0;
    logic [AW+DW+MW:0] m_txn = '0;
    logic [DW-1:0] m_rd = '0;
    logic [N-1:0]  served = '0, exp_wait;
    rsp_rand = 1'b1; spur = 1'b1;
    cyc(); reset = 1'b1; ch_req = '0;
    cyc(); reset = 1'b0;
    for (int c = 0; c < 600; c++) begin
      cyc();
      for (int i = 0; i < N; i++) begin
        if (ch_req[i]) begin
          if (served[i] || $urandom_range(0, 19) == 0) ch_req[i] = 1'b0;
          else if ($urandom_range(0, 3) == 0) set_ch(i, 1'($urandom), AW'($urandom), DW'($urandom), MW'($urandom));
        end else if ($urandom_range(0, 2) == 0) begin
          ch_req[i] = 1'b1;
          set_ch(i, 1'($urandom), AW'($urandom), DW'($urandom), MW'($urandom));
        end
      end
      served = '0;
      #1;
      n_cmp++; if (mem_req !== m_busy) begin n_bad++; $display("FAIL rnd_mem_req_c%0d: got %b want %b", c, mem_req, m_busy); end
      if (m_busy) begin
        n_cmp++; if ({mem_we, mem_addr, mem_wd, mem_mask} !== m_txn) begin n_bad++; $display("FAIL rnd_txn_c%0d: got %h want %h", c, {mem_we, mem_addr, mem_wd, mem_mask}, m_txn); end
      end
      if (m_busy || m_rel) begin
        n_cmp++; if (int'(grant_id) != m_owner) begin n_bad++; $display("FAIL rnd_grant_c%0d: got %0d want %0d", c, grant_id, m_owner); end
      end
      exp_wait = ch_req & ~(m_rel ? (N'(1) << m_owner) : N'(0));
      n_cmp++; if (ch_wait !== exp_wait) begin n_bad++; $display("FAIL rnd_wait_c%0d: got %b want %b", c, ch_wait, exp_wait); end
      if (m_rel && ch_req[m_owner]) begin
        n_cmp++; if (ch_rd[m_owner*DW +: DW] !== m_rd) begin n_bad++; $display("FAIL rnd_rd_c%0d: got %h want %h", c, ch_rd[m_owner*DW +: DW], m_rd); end
      end
      // advance the model to the next cycle
      if (m_rel) begin
        m_rel = 1'b0; served[m_owner] = 1'b1; m_ptr = (m_owner + 1) % N;
      end else if (m_busy) begin
        if (mem_ack) begin m_busy = 1'b0; m_rel = 1'b1; m_rd = mem_rd; end
      end else begin
        for (int k = 0; k < N; k++) begin
          int w;
          w = (m_ptr + k) % N;
          if (ch_req[w]) begin
            m_owner = w; m_busy = 1'b1;
            m_txn = {ch_we[w], ch_addr[w*AW +: AW], ch_wd[w*DW +: DW], ch_mask[w*MW +: MW]};
            break;
          end
        end
      end
    end
    rsp_rand = 1'b0; spur = 1'b0; ch_req = '0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_alternate();
    test_abandon();
    test_reset_busy();
    test_all_four();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
